scroll_scan_ctrl: RTL and testbench
===================================

# scroll_scan_ctrl

Timing controller for the sliding-text display. It drives the 4-digit display multiplexing by producing the digit select `scan_sel` and the active-low anode enables. It also advances the scroll window position `win_idx` around the 12-character message. Its `win_idx` and `scan_sel` outputs feed the character-address calculator, and window changes happen only at frame boundaries so a frame never shows a half-updated window.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `SCROLL_FRAMES`, 100: complete 4-digit frames per scroll step; must be ≥ 1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: run enable; low holds all counters and blanks the display.
- `pause` in 1: freezes scroll; digit scanning continues.
- `dir` in 1: 0 = scroll forward (increment), 1 = scroll reverse (decrement).
- `step` in 1: single-cycle pulse; requests one manual scroll step while paused.
- `win_idx` out 4: window start index, 0..11.
- `scan_sel` out 2: current digit slot, 0..3.
- `digit_an` out 4: anode enables, active-low, one-hot-zero.
- `frame_tick` out 1: one-cycle pulse when `scan_sel` wraps 3→0.
- `scroll_tick` out 1: one-cycle pulse when `win_idx` changes.

## Operation
- Scan prescaler `pcnt` counts 0..SCAN_DIV-1 while `en`=1.
- At terminal count, `pcnt`→0 and `scan_sel` increments mod 4.
- `digit_an` is registered as `~(4'b0001 << next scan_sel)` while `en`=1, and 4'b1111 while `en`=0.
- Frame counter `fcnt` counts 0..SCROLL_FRAMES-1, incrementing on each 3→0 scan wrap.
- A scroll advance is due at a frame wrap when either condition holds:
  - `pause`=0 and `fcnt` is at terminal count; or
  - `pause`=1 and the `step_pend` flag is set.
- Advance arithmetic:
  - Forward: 11→0 wraps, otherwise +1.
  - Reverse: 0→11 wraps, otherwise −1.
  - `win_idx` never leaves 0..11.
- `dir` is sampled at the advance cycle; a direction change mid-frame takes effect at the next advance.
- `step_pend`:
  - Set by `step` while `pause`=1.
  - Cleared when the step advance occurs, or when `pause` falls.
  - Multiple steps within one frame yield one advance.
  - `step` while `pause`=0 is ignored.
  - If `step` arrives in the same cycle as a frame wrap, it is serviced at the next frame wrap.
- While `pause`=1, `fcnt` holds its value.
- `en`=0 holds `pcnt`, `scan_sel`, `fcnt`, `win_idx` and `step_pend`. Counting resumes from the held values when `en` returns high.

## Timing
- All outputs are registered. Reset values: `win_idx`=0, `scan_sel`=0, `digit_an`=4'b1111, `frame_tick`=0, `scroll_tick`=0. Internal `pcnt`, `fcnt` and `step_pend` also reset to 0.
- Reset is asynchronous: asserting `rst` mid-operation forces the reset values immediately, with no clock required.
- `scan_sel` and `digit_an` update together, in the cycle after `pcnt`=SCAN_DIV-1.
- `frame_tick`, `scroll_tick` and the new `win_idx` are registered at the same edge as `scan_sel` 3→0. Downstream therefore sees the new window starting with digit 0.
- The first `digit_an` enable appears 1 cycle after `en` rises.
- `en` falling blanks `digit_an` 1 cycle later.
- Scroll period = SCAN_DIV × 4 × SCROLL_FRAMES cycles.

## Structure
- Shared package `disp_pkg` defines: `MSG_LEN`=12, `NUM_DIGITS`=4, `ADDR_W`=4, `SEL_W`=2. The calculator and this block both import it.
- One sub-module, `mod_counter`, parameterised as `MOD` with `en` and `tc` ports. It is instantiated for the scan prescaler (`MOD`=SCAN_DIV) and for the frame counter (`MOD`=SCROLL_FRAMES).
- Counter widths use `$clog2(MOD)`.
- `win_idx` up/down wrap logic and `step_pend` stay in the top level.

## Test plan
Run with SCAN_DIV=4 and SCROLL_FRAMES=2 (scroll period 32 cycles).
- Assert `rst` → `win_idx`=0, `scan_sel`=0, `digit_an`=1111, both ticks 0, with no clock edge needed.
- `en`=1 → `scan_sel` steps 0,1,2,3,0 every 4 cycles; `digit_an` goes 1110, 1101, 1011, 0111; `frame_tick` pulses every 16 cycles.
- Forward scroll, `dir`=0 → `win_idx` 0→1 at cycle 32, on the same edge as `scan_sel` 3→0 with `scroll_tick`=1. Starting from 11, the next advance gives 0.
- Reverse scroll: set `dir`=1 at `win_idx`=0 → next advance gives 11, then 10.
- Pause and step:
  - `pause`=1 for 100 cycles → `win_idx` constant, scanning continues.
  - Two `step` pulses within one frame → exactly one advance, at the next frame wrap.
  - `step` with `pause`=0 → no extra advance.
- Enable and reset mid-operation:
  - `en`=0 at `scan_sel`=2, `win_idx`=7 → `digit_an`=1111 next cycle, values held; re-enable resumes at `scan_sel`=2.
  - Async `rst` mid-slot → all outputs at reset values immediately.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants for the sliding-text display: message length, digit count and
// the index/select widths used by this controller and the character-address calculator.
package disp_pkg;

    localparam int unsigned MSG_LEN    = 12;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned SEL_W      = 2;

    typedef logic [ADDR_W-1:0]     win_idx_t;
    typedef logic [SEL_W-1:0]      scan_sel_t;
    typedef logic [NUM_DIGITS-1:0] digit_an_t;

    localparam win_idx_t  LAST_IDX  = win_idx_t'(MSG_LEN - 1);
    localparam scan_sel_t LAST_SEL  = scan_sel_t'(NUM_DIGITS - 1);
    localparam digit_an_t AN_BLANK  = '1;

    // Active-low one-hot anode pattern for a digit slot.
    function automatic digit_an_t an_for_sel(input scan_sel_t sel);
        digit_an_t onehot;
        onehot = digit_an_t'(1) << sel;
        return ~onehot;
    endfunction

endpackage

// File: rtl/scroll_scan_ctrl_if.sv
// Control and display-timing signals between the scroll/scan controller and its
// surroundings; slave is the controller's view, master the driving side.
interface scroll_scan_ctrl_if
    import disp_pkg::*;
();

    logic      en;
    logic      pause;
    logic      dir;
    logic      step;
    win_idx_t  win_idx;
    scan_sel_t scan_sel;
    digit_an_t digit_an;
    logic      frame_tick;
    logic      scroll_tick;

    modport master (
        output en,
        output pause,
        output dir,
        output step,
        input  win_idx,
        input  scan_sel,
        input  digit_an,
        input  frame_tick,
        input  scroll_tick
    );

    modport slave (
        input  en,
        input  pause,
        input  dir,
        input  step,
        output win_idx,
        output scan_sel,
        output digit_an,
        output frame_tick,
        output scroll_tick
    );

endinterface

// File: rtl/scroll_scan_ctrl_mod_counter.sv
// Modulo-MOD counter with enable; tc_o flags the enabled cycle at MOD-1, after
// which the count returns to zero.
module mod_counter #(
    parameter int unsigned MOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned W = (MOD > 1) ? $clog2(MOD) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && (cnt_q == W'(MOD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scroll_scan_ctrl.sv
// Display multiplex and scroll timing: scans four digit slots and moves the message
// window only at frame boundaries so every frame shows one consistent window.
module scroll_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV      = 50000,
    parameter int unsigned SCROLL_FRAMES = 100
) (
    input logic               clk,
    input logic               rst,
    scroll_scan_ctrl_if.slave ctrl
);

    logic pre_tc;
    logic frame_wrap;
    logic frame_en;
    logic frame_tc;
    logic advance;

    scan_sel_t scan_sel_q, scan_sel_d;
    digit_an_t digit_an_q, digit_an_d;
    win_idx_t  win_idx_q, win_idx_d;
    logic      frame_tick_q, frame_tick_d;
    logic      scroll_tick_q, scroll_tick_d;
    logic      step_pend_q, step_pend_d;

    mod_counter #(
        .MOD (SCAN_DIV)
    ) u_scan_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en_i (ctrl.en),
        .tc_o (pre_tc)
    );

    // pre_tc is already gated by en, so a held controller never sees a frame wrap.
    assign frame_wrap = pre_tc && (scan_sel_q == LAST_SEL);
    assign frame_en   = frame_wrap && !ctrl.pause;

    mod_counter #(
        .MOD (SCROLL_FRAMES)
    ) u_frame_counter (
        .clk  (clk),
        .rst  (rst),
        .en_i (frame_en),
        .tc_o (frame_tc)
    );

    assign advance = frame_wrap && (frame_tc || (ctrl.pause && step_pend_q));

    always_comb begin
        scan_sel_d = scan_sel_q;
        if (pre_tc) begin
            scan_sel_d = scan_sel_q + scan_sel_t'(1);
        end
        digit_an_d    = ctrl.en ? an_for_sel(scan_sel_d) : AN_BLANK;
        frame_tick_d  = frame_wrap;
        scroll_tick_d = advance;
    end

    always_comb begin
        win_idx_d = win_idx_q;
        if (advance) begin
            if (ctrl.dir) begin
                win_idx_d = (win_idx_q == '0) ? LAST_IDX : win_idx_q - win_idx_t'(1);
            end else begin
                win_idx_d = (win_idx_q >= LAST_IDX) ? '0 : win_idx_q + win_idx_t'(1);
            end
        end
    end

    // A step coinciding with a wrap is kept pending for the following wrap.
    always_comb begin
        step_pend_d = step_pend_q;
        if (ctrl.en) begin
            if (!ctrl.pause) begin
                step_pend_d = 1'b0;
            end else if (ctrl.step) begin
                step_pend_d = 1'b1;
            end else if (advance) begin
                step_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_sel_q    <= '0;
            digit_an_q    <= AN_BLANK;
            win_idx_q     <= '0;
            frame_tick_q  <= 1'b0;
            scroll_tick_q <= 1'b0;
            step_pend_q   <= 1'b0;
        end else begin
            scan_sel_q    <= scan_sel_d;
            digit_an_q    <= digit_an_d;
            win_idx_q     <= win_idx_d;
            frame_tick_q  <= frame_tick_d;
            scroll_tick_q <= scroll_tick_d;
            step_pend_q   <= step_pend_d;
        end
    end

    assign ctrl.scan_sel    = scan_sel_q;
    assign ctrl.digit_an    = digit_an_q;
    assign ctrl.win_idx     = win_idx_q;
    assign ctrl.frame_tick  = frame_tick_q;
    assign ctrl.scroll_tick = scroll_tick_q;

endmodule

// File: tb/tb_scroll_scan_ctrl.sv
// Directed bench for scroll_scan_ctrl with SCAN_DIV=4, SCROLL_FRAMES=2 (32-cycle scroll).
module tb_scroll_scan_ctrl;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    scroll_scan_ctrl_if dut_if ();

    scroll_scan_ctrl #(
        .SCAN_DIV      (4),
        .SCROLL_FRAMES (2)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (dut_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n posedges, returning at the following negedge for sampling/driving.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int win, input int sel, input int an,
                             input int ft, input int st);
        check({tag, ".win"},  int'(dut_if.win_idx),     win);
        check({tag, ".sel"},  int'(dut_if.scan_sel),    sel);
        check({tag, ".an"},   int'(dut_if.digit_an),    an);
        check({tag, ".ftk"},  int'(dut_if.frame_tick),  ft);
        check({tag, ".stk"},  int'(dut_if.scroll_tick), st);
    endtask

    initial begin
        rst          = 1'b0;
        dut_if.en    = 1'b0;
        dut_if.pause = 1'b0;
        dut_if.dir   = 1'b0;
        dut_if.step  = 1'b0;
        #1 rst = 1'b1;
        #1 check_all("rst_async", 0, 0, 'b1111, 0, 0);

        @(negedge clk);
        rst = 1'b0;
        cyc(1);
        check_all("idle_en0", 0, 0, 'b1111, 0, 0);

        // Scan sequence; E<n> = n-th posedge after en rises.
        dut_if.en = 1'b1;
        cyc(1);
        check_all("E1", 0, 0, 'b1110, 0, 0);
        cyc(3);
        check_all("E4", 0, 1, 'b1101, 0, 0);
        cyc(4);
        check_all("E8", 0, 2, 'b1011, 0, 0);
        cyc(4);
        check_all("E12", 0, 3, 'b0111, 0, 0);
        cyc(4);
        check_all("E16", 0, 0, 'b1110, 1, 0);
        cyc(1);
        check_all("E17", 0, 0, 'b1110, 0, 0);
        cyc(14);
        check_all("E31", 0, 3, 'b0111, 0, 0);
        cyc(1);
        check_all("E32", 1, 0, 'b1110, 1, 1);

        // Ten more forward advances reach 11, then wrap to 0.
        cyc(320);
        check_all("fwd_11", 11, 0, 'b1110, 1, 1);
        cyc(32);
        check_all("fwd_wrap", 0, 0, 'b1110, 1, 1);

        dut_if.dir = 1'b1;
        cyc(32);
        check_all("rev_11", 11, 0, 'b1110, 1, 1);
        cyc(32);
        check_all("rev_10", 10, 0, 'b1110, 1, 1);
        dut_if.dir = 1'b0;

        // Pause for 100 cycles: window frozen, scanning continues.
        dut_if.pause = 1'b1;
        cyc(100);
        check_all("pause100", 10, 1, 'b1101, 0, 0);

        dut_if.step = 1'b1;
        cyc(1);
        dut_if.step = 1'b0;
        cyc(2);
        dut_if.step = 1'b1;
        cyc(1);
        dut_if.step = 1'b0;
        cyc(7);
        check_all("step_pre", 10, 3, 'b0111, 0, 0);
        cyc(1);
        check_all("step_adv", 11, 0, 'b1110, 1, 1);
        cyc(16);
        check_all("step_once", 11, 0, 'b1110, 1, 0);

        // Unpause; a step now must not add an advance.
        dut_if.pause = 1'b0;
        dut_if.step  = 1'b1;
        cyc(1);
        dut_if.step  = 1'b0;
        cyc(15);
        check_all("nostep", 11, 0, 'b1110, 1, 0);
        cyc(16);
        check_all("resume_adv", 0, 0, 'b1110, 1, 1);

        // Seven advances to window 7, then two slots to scan_sel 2.
        cyc(224);
        check("win7", int'(dut_if.win_idx), 7);
        cyc(8);
        check_all("pre_hold", 7, 2, 'b1011, 0, 0);
        dut_if.en = 1'b0;
        cyc(1);
        check_all("hold1", 7, 2, 'b1111, 0, 0);
        cyc(20);
        check_all("hold21", 7, 2, 'b1111, 0, 0);
        dut_if.en = 1'b1;
        cyc(1);
        check_all("reen1", 7, 2, 'b1011, 0, 0);
        cyc(3);
        check_all("reen4", 7, 3, 'b0111, 0, 0);

        // Asynchronous reset between edges.
        cyc(2);
        #2 rst = 1'b1;
        #1 check_all("rst_mid", 0, 0, 'b1111, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        dut_if.en = 1'b0;
        cyc(2);
        check_all("post_rst", 0, 0, 'b1111, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
